// File: rtl/count_direction_decoder.sv
// Receive-side checker for an up/down counter stream: decodes the counting direction,
// flags wrap-around steps and counts illegal steps with a saturating counter.
module count_direction_decoder #(
   parameter int WIDTH         = 4,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     clear,
   input  logic                     sample_valid,
   input  logic [WIDTH-1:0]         count_in,
   output logic                     direction,
   output logic                     dir_locked,
   output logic                     wrap_pulse,
   output logic                     step_error,
   output logic [ERR_CNT_WIDTH-1:0] error_count,
   output logic [WIDTH-1:0]         last_count
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FIRST = 2'd1,
      ST_UP    = 2'd2,
      ST_DOWN  = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]         CNT_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]         CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = {ERR_CNT_WIDTH{1'b1}};

   state_t                   state_q, state_d;
   logic                     direction_q, direction_d;
   logic                     locked_q, locked_d;
   logic                     wrap_q, wrap_d;
   logic                     step_err_q, step_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]         last_q, last_d;

   logic [WIDTH-1:0]         inc_s, dec_s, mir_dn_s, mir_up_s;
   logic                     illegal_s;

   // Candidate successors of the last accepted sample.
   always_comb begin
      inc_s    = last_q + WIDTH'(1);
      dec_s    = last_q - WIDTH'(1);
      mir_dn_s = ~last_q;
      mir_up_s = ~last_q + WIDTH'(2);
   end

   // Next-state decode; +/-1 steps are tested before mirror jumps so they win ties.
   always_comb begin
      state_d     = state_q;
      direction_d = direction_q;
      locked_d    = locked_q;
      wrap_d      = 1'b0;
      step_err_d  = 1'b0;
      err_cnt_d   = err_cnt_q;
      last_d      = last_q;
      illegal_s   = 1'b0;

      if (sample_valid) begin
         last_d = count_in;
         case (state_q)
            ST_EMPTY: begin
               state_d  = ST_FIRST;
               locked_d = 1'b0;
            end
            ST_FIRST: begin
               if (count_in == inc_s) begin
                  state_d     = ST_UP;
                  direction_d = 1'b0;
                  locked_d    = 1'b1;
                  wrap_d      = (last_q == CNT_ONES);
               end else if (count_in == dec_s) begin
                  state_d     = ST_DOWN;
                  direction_d = 1'b1;
                  locked_d    = 1'b1;
                  wrap_d      = (last_q == CNT_ZERO);
               end else begin
                  illegal_s = 1'b1;
               end
            end
            ST_UP: begin
               if (count_in == inc_s) begin
                  state_d = ST_UP;
                  wrap_d  = (last_q == CNT_ONES);
               end else if (count_in == mir_dn_s) begin
                  state_d     = ST_DOWN;
                  direction_d = 1'b1;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            ST_DOWN: begin
               if (count_in == dec_s) begin
                  state_d = ST_DOWN;
                  wrap_d  = (last_q == CNT_ZERO);
               end else if (count_in == mir_up_s) begin
                  state_d     = ST_UP;
                  direction_d = 1'b0;
               end else begin
                  illegal_s = 1'b1;
               end
            end
            default: begin
               state_d  = ST_EMPTY;
               locked_d = 1'b0;
            end
         endcase

         // Illegal step: drop the lock and look for a fresh pair; direction keeps its value.
         if (illegal_s) begin
            state_d    = ST_FIRST;
            locked_d   = 1'b0;
            step_err_d = 1'b1;
            if (err_cnt_q != ERR_MAX) begin
               err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end else begin
               err_cnt_d = err_cnt_q;
            end
         end else begin
            step_err_d = 1'b0;
         end
      end else begin
         state_d  = ST_EMPTY;
         locked_d = 1'b0;
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q     <= ST_EMPTY;
         direction_q <= 1'b0;
         locked_q    <= 1'b0;
         wrap_q      <= 1'b0;
         step_err_q  <= 1'b0;
         err_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
         last_q      <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         direction_q <= direction_d;
         locked_q    <= locked_d;
         wrap_q      <= wrap_d;
         step_err_q  <= step_err_d;
         err_cnt_q   <= err_cnt_d;
         last_q      <= last_d;
      end
   end

   assign direction   = direction_q;
   assign dir_locked  = locked_q;
   assign wrap_pulse  = wrap_q;
   assign step_error  = step_err_q;
   assign error_count = err_cnt_q;
   assign last_count  = last_q;

endmodule
